// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: request/response port of one memory requester.
//   master modport - requester side (drives req/we/addr/wdata, receives rdata/ack/err)
//   slave  modport - arbiter side
// Signals:
//   req    access request, held until ack
//   we     1 = write
//   addr   access address
//   wdata  write data
//   rdata  registered read data, valid with ack
//   ack    one-cycle completion pulse
//   err    one-cycle pulse with ack when the access was blocked
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;
  logic              err;

  modport master (output req, we, addr, wdata, input rdata, ack, err);
  modport slave  (input req, we, addr, wdata, output rdata, ack, err);
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between the core datapath
// and an external loader/debug port. Core has fixed priority; after
// MAX_CORE_BURST consecutive core grants made while ext is waiting, ext wins.
// One command is latched per grant, driven to memory for one cycle, and a
// registered one-cycle ack is returned to the owner.
//
// Optional build macro: MEM_ARB_PROTECT_EN - ext writes below EXT_WR_BASE are
// blocked at grant and answered with ext ack + ext err, without a memory cycle.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   core (slave)      core requester port (err always 0)
//   ext  (slave)      external requester port
//   mem_en/mem_we     memory strobe / write enable (high only in ISSUE)
//   mem_addr/wdata    memory address / write data
//   mem_rdata         memory read data, sampled MEM_LAT cycles after ISSUE
//   busy              high whenever the FSM is not IDLE
//
// state | meaning
// IDLE  | arbitrate pending requests, latch winner's command
// ISSUE | memory strobe for one cycle
// WAIT  | counting read latency, capture mem_rdata at terminal count
// RESP  | one-cycle ack (and err) to the owner
module mem_port_arbiter #(
  parameter int              ADDR_W         = 32,
  parameter int              DATA_W         = 32,
  parameter int              MEM_LAT        = 2,
  parameter int              MAX_CORE_BURST = 4,
  parameter logic [ADDR_W-1:0] EXT_WR_BASE  = 'h0000_1000
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_port_arbiter_if.slave  core,
  mem_port_arbiter_if.slave  ext,
  output logic               mem_en,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic [DATA_W-1:0]  mem_rdata,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam int STREAK_W = (MAX_CORE_BURST > 0) ? $clog2(MAX_CORE_BURST + 1) : 1;
  localparam int LAT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_CORE_BURST);
  localparam logic [LAT_W-1:0]    LAT_LOAD   = LAT_W'(MEM_LAT - 1);

  state_t              state;
  logic                owner_ext;
  logic [STREAK_W-1:0] streak;
  logic [LAT_W-1:0]    lat_cnt;
  logic [DATA_W-1:0]   core_rdata_q;
  logic [DATA_W-1:0]   ext_rdata_q;
  logic                core_ack_q;
  logic                ext_ack_q;
  logic                ext_err_q;
  logic                grant_ext;
  logic                ext_blocked;

  always_comb begin
    grant_ext = ext.req && (!core.req || (streak == STREAK_MAX));
  end

`ifdef MEM_ARB_PROTECT_EN
  assign ext_blocked = ext.we && (ext.addr < EXT_WR_BASE);
`else
  assign ext_blocked = 1'b0;
`endif

  // The latched command lives directly in the mem_* output registers; they
  // are valid only during ISSUE and return to zero afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      owner_ext    <= 1'b0;
      streak       <= '0;
      lat_cnt      <= '0;
      core_rdata_q <= '0;
      ext_rdata_q  <= '0;
      core_ack_q   <= 1'b0;
      ext_ack_q    <= 1'b0;
      ext_err_q    <= 1'b0;
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
    end else begin
      core_ack_q <= 1'b0;
      ext_ack_q  <= 1'b0;
      ext_err_q  <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      case (state)
        IDLE: begin
          if (core.req || ext.req) begin
            owner_ext <= grant_ext;
            if (grant_ext) begin
              streak <= '0;
            end else if (!ext.req) begin
              streak <= '0;
            end else if (streak != STREAK_MAX) begin
              streak <= streak + 1'b1;
            end
            if (grant_ext && ext_blocked) begin
              ext_ack_q <= 1'b1;
              ext_err_q <= 1'b1;
              state     <= RESP;
            end else begin
              mem_en    <= 1'b1;
              mem_we    <= grant_ext ? ext.we    : core.we;
              mem_addr  <= grant_ext ? ext.addr  : core.addr;
              mem_wdata <= grant_ext ? ext.wdata : core.wdata;
              state     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (mem_we) begin
            core_ack_q <= !owner_ext;
            ext_ack_q  <= owner_ext;
            state      <= RESP;
          end else begin
            lat_cnt <= LAT_LOAD;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (lat_cnt == '0) begin
            if (owner_ext) begin
              ext_rdata_q <= mem_rdata;
              ext_ack_q   <= 1'b1;
            end else begin
              core_rdata_q <= mem_rdata;
              core_ack_q   <= 1'b1;
            end
            state <= RESP;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy       = (state != IDLE);
  assign core.rdata = core_rdata_q;
  assign core.ack   = core_ack_q;
  assign core.err   = 1'b0;
  assign ext.rdata  = ext_rdata_q;
  assign ext.ack    = ext_ack_q;
  assign ext.err    = ext_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic,
// checked each cycle against a transaction-level reference model.
module tb_mem_port_arbiter;
  localparam int          AW      = 32;
  localparam int          DW      = 32;
  localparam int          LAT     = 2;
  localparam int          BURST   = 4;
  localparam logic [31:0] WR_BASE = 32'h0000_1000;
`ifdef MEM_ARB_PROTECT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) core_if ();
  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ext_if ();
  logic          mem_en, mem_we, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT),
                     .MAX_CORE_BURST(BURST), .EXT_WR_BASE(WR_BASE)) dut (
    .clk(clk), .rst_n(rst_n), .core(core_if), .ext(ext_if),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy));

  int checks = 0;
  int errors = 0;

  // memory seen by the DUT, and the independent reference copy
  logic [31:0] mem_arr [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  int          rd_due[$];
  logic [31:0] rd_addr[$];

  // reference model: one outstanding transaction
  int          cyc = 0;
  int          next_idle = 0;
  int          streak_m = 0;
  bit          t_act, t_ext, t_we, t_blk;
  logic [31:0] t_addr, t_wdata, t_rdata;
  int          t_grant, t_issue, t_ack;
  logic [31:0] exp_core_rd, exp_ext_rd;
  bit          ack_c_now, ack_e_now;
  bit          granted [2];
  int          pol [2];
  logic [9:0]  ord;
  int          n_acks;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] raddr();
    return ($urandom_range(0, 1) ? 32'h1000 : 32'h0) | (32'($urandom_range(0, 7)) << 2);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_cmd(input int p, input bit rq, input bit we,
                         input logic [31:0] a, input logic [31:0] d);
    if (p == 0) begin
      core_if.req = rq; core_if.we = we; core_if.addr = a; core_if.wdata = d;
    end else begin
      ext_if.req = rq; ext_if.we = we; ext_if.addr = a; ext_if.wdata = d;
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_core_ack"}, core_if.ack, 0);
    chk({tag, "_ext_ack"}, ext_if.ack, 0);
    chk({tag, "_ext_err"}, ext_if.err, 0);
    chk({tag, "_core_rdata"}, core_if.rdata, 0);
    chk({tag, "_ext_rdata"}, ext_if.rdata, 0);
    chk({tag, "_mem_en"}, mem_en, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  // assert reset mid-cycle, check outputs at once, release mid-cycle
  task automatic do_reset();
    rst_n = 1'b0;
    set_cmd(0, 0, 0, '0, '0);
    set_cmd(1, 0, 0, '0, '0);
    mem_rdata = '0;
    #1;
    check_all_zero("reset");
    t_act = 0; streak_m = 0; exp_core_rd = '0; exp_ext_rd = '0;
    ack_c_now = 0; ack_e_now = 0; granted[0] = 0; granted[1] = 0;
    pol[0] = 0; pol[1] = 0;
    rd_due.delete(); rd_addr.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    next_idle = cyc;
  endtask

  task automatic step();
    bit rq, acked, ge, ec, ee, iss;
    // memory behaviour for this cycle
    if (rd_due.size() > 0 && rd_due[0] == cyc) begin
      mem_rdata = mem_arr.exists(rd_addr[0]) ? mem_arr[rd_addr[0]] : dflt(rd_addr[0]);
      void'(rd_due.pop_front());
      void'(rd_addr.pop_front());
    end else begin
      mem_rdata = $urandom;
    end
    if (mem_en === 1'b1) begin
      if (mem_we) mem_arr[mem_addr] = mem_wdata;
      else begin
        rd_due.push_back(cyc + LAT);
        rd_addr.push_back(mem_addr);
      end
    end
    // requesters
    for (int p = 0; p < 2; p++) begin
      rq    = (p == 0) ? core_if.req : ext_if.req;
      acked = (p == 0) ? ack_c_now : ack_e_now;
      if (acked) begin
        granted[p] = 0;
        if (pol[p] == 2) set_cmd(p, 1, 0, raddr(), $urandom);
        else if (pol[p] == 1 && $urandom_range(0, 1) == 1)
          set_cmd(p, 1, 1'($urandom_range(0, 1)), raddr(), $urandom);
        else set_cmd(p, 0, 0, '0, '0);
      end else if (!rq) begin
        if (pol[p] == 2) set_cmd(p, 1, 0, raddr(), $urandom);
        else if (pol[p] == 1 && $urandom_range(0, 2) == 0)
          set_cmd(p, 1, 1'($urandom_range(0, 1)), raddr(), $urandom);
      end else if (granted[p] || (pol[p] == 1 && $urandom_range(0, 3) == 0)) begin
        set_cmd(p, 1, 1'($urandom_range(0, 1)), raddr(), $urandom);
      end
    end
    // model grant: priority to core, ext forced after BURST core wins in a row
    if (!t_act && cyc >= next_idle && (core_if.req || ext_if.req)) begin
      ge      = ext_if.req && (!core_if.req || streak_m == BURST);
      t_ext   = ge;
      t_we    = ge ? ext_if.we : core_if.we;
      t_addr  = ge ? ext_if.addr : core_if.addr;
      t_wdata = ge ? ext_if.wdata : core_if.wdata;
      t_blk   = PROT && ge && t_we && (t_addr < WR_BASE);
      if (ge || !ext_if.req) streak_m = 0;
      else if (streak_m < BURST) streak_m++;
      t_act   = 1;
      t_grant = cyc;
      t_issue = cyc + 1;
      t_ack   = t_blk ? cyc + 1 : (t_we ? cyc + 2 : cyc + 2 + LAT);
      next_idle = t_ack + 1;
      if (t_we && !t_blk) ref_mem[t_addr] = t_wdata;
      if (!t_we) t_rdata = ref_mem.exists(t_addr) ? ref_mem[t_addr] : dflt(t_addr);
      granted[ge ? 1 : 0] = 1;
    end
    // advance and compare
    @(posedge clk); #1;
    cyc++;
    ec  = t_act && !t_ext && cyc == t_ack;
    ee  = t_act && t_ext && cyc == t_ack;
    iss = t_act && !t_blk && cyc == t_issue;
    if (ec && !t_we) exp_core_rd = t_rdata;
    if (ee && !t_we) exp_ext_rd = t_rdata;
    chk("core_ack", core_if.ack, ec);
    chk("ext_ack", ext_if.ack, ee);
    chk("ext_err", ext_if.err, ee && t_blk);
    chk("core_err", core_if.err, 0);
    chk("core_rdata", core_if.rdata, exp_core_rd);
    chk("ext_rdata", ext_if.rdata, exp_ext_rd);
    chk("mem_en", mem_en, iss);
    if (iss) begin
      chk("mem_we", mem_we, t_we);
      chk("mem_addr", mem_addr, t_addr);
      chk("mem_wdata", mem_wdata, t_wdata);
    end
    chk("busy", busy, t_act && cyc > t_grant && cyc <= t_ack);
    if (n_acks < 10 && (core_if.ack === 1'b1 || ext_if.ack === 1'b1)) begin
      ord[n_acks] = ext_if.ack;
      n_acks++;
    end
    ack_c_now = ec;
    ack_e_now = ee;
    if (t_act && cyc == t_ack) t_act = 0;
  endtask

  initial begin
    set_cmd(0, 0, 0, '0, '0);
    set_cmd(1, 0, 0, '0, '0);
    mem_rdata = '0;
    ord = '0;
    n_acks = 0;

    // core read of 0x10, memory returns 0xDEADBEEF
    do_reset();
    mem_arr[32'h10] = 32'hDEAD_BEEF;
    ref_mem[32'h10] = 32'hDEAD_BEEF;
    set_cmd(0, 1, 0, 32'h10, 32'h0);
    repeat (8) step();
    chk("t1_core_rdata", core_if.rdata, 32'hDEAD_BEEF);

    // ext write to 0x2000
    set_cmd(1, 1, 1, 32'h2000, 32'h55);
    repeat (6) step();
    chk("t2_core_rdata_held", core_if.rdata, 32'hDEAD_BEEF);

    // simultaneous requests; ext address changes while waiting
    set_cmd(0, 1, 0, 32'h1004, 32'h0);
    set_cmd(1, 1, 0, 32'h1000, 32'h0);
    step();
    set_cmd(1, 1, 0, 32'h1010, 32'h0);
    repeat (14) step();

    // continuous requests from both: order C,C,C,C,E,C,C,C,C,E
    do_reset();
    pol[0] = 2; pol[1] = 2;
    n_acks = 0; ord = '0;
    for (int i = 0; i < 200 && n_acks < 10; i++) step();
    chk("grant_order", ord, 10'h210);
    pol[0] = 0; pol[1] = 0;
    repeat (12) step();

    // reset during WAIT of a core read, then a normal ext read
    do_reset();
    set_cmd(0, 1, 0, 32'h40, 32'h0);
    repeat (2) step();
    chk("t5_busy_in_wait", busy, 1);
    do_reset();
    repeat (8) step();
    set_cmd(1, 1, 0, 32'h1008, 32'h0);
    repeat (8) step();

    // ext write below the protected base
    set_cmd(1, 1, 1, 32'h0, 32'hABCD);
    repeat (5) step();

    // randomized traffic, then drain
    do_reset();
    pol[0] = 1; pol[1] = 1;
    repeat (800) step();
    pol[0] = 0; pol[1] = 0;
    repeat (30) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
